// File: rtl/wb_slave_ram_pkg.sv
// Shared definitions for the Wishbone RAM slave: bus widths, wait counter width, FSM states.
package wb_defines;
    localparam int DATA_WIDTH = 32;
    localparam int SEL_WIDTH  = 4;
    localparam int CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_HOLD = 2'd3
    } state_t;
endpackage

// File: rtl/wb_ram_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module wb_ram_array
    import wb_defines::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [SEL_WIDTH-1:0]  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < SEL_WIDTH; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/wb_slave_ram.sv
// Wishbone classic slave over a word RAM with programmable wait states.
// Define WB_RAM_ERR_EN to terminate out-of-range accesses with err instead of wrapping.
module wb_slave_ram
    import wb_defines::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           wishbone_addr_i,
    input  logic [DATA_WIDTH-1:0] wishbone_data_i,
    input  logic                  wishbone_we_i,
    input  logic [SEL_WIDTH-1:0]  wishbone_sel_i,
    input  logic                  wishbone_stb_i,
    input  logic                  wishbone_cyc_i,
    output logic [DATA_WIDTH-1:0] wishbone_data_o,
    output logic                  wishbone_ack_o,
    output logic                  wishbone_err_o
);
    state_t                state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  we_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic                  cur_we;
    logic [SEL_WIDTH-1:0]  cur_sel;
    logic [DATA_WIDTH-1:0] cur_data;
    logic                  cur_err;
    logic                  req;
    logic                  go_resp;
    logic [SEL_WIDTH-1:0]  ram_we;
    logic                  ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  unused_bits;

    assign req = wishbone_cyc_i & wishbone_stb_i;

`ifdef WB_RAM_ERR_EN
    logic range_q;
    logic range_in;

    assign range_in    = |wishbone_addr_i[31:ADDR_WIDTH+2];
    assign cur_err     = (state == S_IDLE) ? range_in : range_q;
    assign unused_bits = ^wishbone_addr_i[1:0];

    always_ff @(posedge clk) begin
        if (state == S_IDLE && req) begin
            range_q <= range_in;
        end
    end
`else
    assign cur_err     = 1'b0;
    assign unused_bits = ^{wishbone_addr_i[31:ADDR_WIDTH+2], wishbone_addr_i[1:0]};
`endif

    // With zero wait states the RAM is accessed on the sampling edge itself, so use the live bus.
    always_comb begin
        if (state == S_IDLE) begin
            cur_idx  = wishbone_addr_i[ADDR_WIDTH+1:2];
            cur_we   = wishbone_we_i;
            cur_sel  = wishbone_sel_i;
            cur_data = wishbone_data_i;
        end else begin
            cur_idx  = idx_q;
            cur_we   = we_q;
            cur_sel  = sel_q;
            cur_data = data_q;
        end
    end

    always_comb begin
        go_resp = 1'b0;
        if (rst) begin
            if (state == S_IDLE) begin
                go_resp = req && (WAIT_STATES == 0);
            end else if (state == S_WAIT) begin
                go_resp = req && (cnt == '0);
            end
        end
    end

    assign ram_we = {SEL_WIDTH{go_resp & cur_we & ~cur_err}} & cur_sel;
    assign ram_re = go_resp & ~cur_we & ~cur_err;

    wb_ram_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (cur_idx),
        .wdata (cur_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (state == S_IDLE && req) begin
            idx_q  <= wishbone_addr_i[ADDR_WIDTH+1:2];
            we_q   <= wishbone_we_i;
            sel_q  <= wishbone_sel_i;
            data_q <= wishbone_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            wishbone_ack_o <= 1'b0;
            wishbone_err_o <= 1'b0;
        end else begin
            wishbone_ack_o <= go_resp & ~cur_err;
            wishbone_err_o <= go_resp & cur_err;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        if (WAIT_STATES == 0) begin
                            state <= S_RESP;
                        end else begin
                            cnt   <= CNT_WIDTH'(WAIT_STATES - 1);
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: state <= S_HOLD;
                // The master must release stb before another request is accepted.
                S_HOLD: begin
                    if (!wishbone_stb_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign wishbone_data_o = (wishbone_ack_o && !we_q) ? ram_rdata : '0;
endmodule

// File: tb/tb_wb_slave_ram.sv
// Self-checking bench for wb_slave_ram: scoreboarded transactions on a WAIT_STATES=1 instance
// plus a held-strobe check on a WAIT_STATES=0 instance.
module tb_wb_slave_ram;
    localparam int AW = 10;
    localparam int WS = 1;

    typedef struct {
        logic        is_err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        we0;
    logic [3:0]  sel0;
    logic        stb0;
    logic        cyc0;
    logic [31:0] rdata0;
    logic        ack0;
    logic        err0;

    exp_t        exp_q[$];
    logic [31:0] model [0:(2**AW)-1];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    wb_slave_ram #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clk             (clk),
        .rst             (rst),
        .wishbone_addr_i (addr),
        .wishbone_data_i (wdata),
        .wishbone_we_i   (we),
        .wishbone_sel_i  (sel),
        .wishbone_stb_i  (stb),
        .wishbone_cyc_i  (cyc),
        .wishbone_data_o (rdata),
        .wishbone_ack_o  (ack),
        .wishbone_err_o  (err)
    );

    wb_slave_ram #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .clk             (clk),
        .rst             (rst),
        .wishbone_addr_i (addr0),
        .wishbone_data_i (wdata0),
        .wishbone_we_i   (we0),
        .wishbone_sel_i  (sel0),
        .wishbone_stb_i  (stb0),
        .wishbone_cyc_i  (cyc0),
        .wishbone_data_o (rdata0),
        .wishbone_ack_o  (ack0),
        .wishbone_err_o  (err0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] mergeLanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // One complete transaction on the WAIT_STATES=1 instance; called from an idle bus after an edge.
    task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [3:0] s,
                                 input logic [31:0] d);
        exp_t       e;
        int         n;
        logic       seen;
        logic       range_bad;
        logic [9:0] idx;
        idx = a[11:2];
`ifdef WB_RAM_ERR_EN
        range_bad = (a[31:12] != 20'd0);
`else
        range_bad = 1'b0;
`endif
        e.is_err = range_bad;
        if (range_bad || w) begin
            e.data = 32'd0;
        end else begin
            e.data = model[idx];
        end
        if (w && !range_bad) model[idx] = mergeLanes(model[idx], d, s);
        exp_q.push_back(e);

        addr = a; we = w; sel = s; wdata = d; cyc = 1'b1; stb = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            seen = ack | err;
        end
        e = exp_q.pop_front();
        if (!seen) begin
            checkOutput("timeout", 32'd0, 32'd1);
        end else begin
            checkOutput("latency", 32'(n), 32'(WS + 1));
            checkOutput("ack", {31'd0, ack}, {31'd0, !e.is_err});
            checkOutput("err", {31'd0, err}, {31'd0, e.is_err});
            checkOutput("data", rdata, e.data);
            @(posedge clk); #1;
            checkOutput("pulse", {30'd0, ack, err}, 32'd0);
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int          acks;
        int          first;
        logic        bad_seen;
        logic [31:0] got;
        logic [31:0] ra;
        logic [31:0] rd;

        addr = '0; wdata = '0; we = 1'b0; sel = '0; stb = 1'b0; cyc = 1'b0;
        addr0 = '0; wdata0 = '0; we0 = 1'b0; sel0 = '0; stb0 = 1'b0; cyc0 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ack", {31'd0, ack}, 32'd0);
        checkOutput("reset_err", {31'd0, err}, 32'd0);
        checkOutput("reset_data", rdata, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        applyStimulus(32'h10, 1'b1, 4'b1111, 32'hDEADBEEF);
        applyStimulus(32'h10, 1'b0, 4'b0000, 32'h0);

        applyStimulus(32'h20, 1'b1, 4'b1111, 32'h11223344);
        applyStimulus(32'h20, 1'b1, 4'b0101, 32'hAABBCCDD);
        applyStimulus(32'h20, 1'b0, 4'b1111, 32'h0);
        checkOutput("lane_model", model[8], 32'h11BB33DD);

        // Abort: strobe drops while the slave is in its wait state.
        addr = 32'h20; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        bad_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack || err) bad_seen = 1'b1;
        end
        checkOutput("abort_no_resp", {31'd0, bad_seen}, 32'd0);
        applyStimulus(32'h10, 1'b0, 4'b1111, 32'h0);

        // Reset during the wait state of a write must drop the write.
        addr = 32'h10; we = 1'b1; sel = 4'hF; wdata = 32'h55555555; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_mid_ack", {31'd0, ack}, 32'd0);
        checkOutput("rst_mid_err", {31'd0, err}, 32'd0);
        checkOutput("rst_mid_data", rdata, 32'd0);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        applyStimulus(32'h10, 1'b0, 4'b1111, 32'h0);

        // Out-of-range write: err when the range check is built in, wrap to word 0 otherwise.
        applyStimulus(32'h0, 1'b1, 4'b1111, 32'h01020304);
        applyStimulus(32'h0000_1000, 1'b1, 4'b1111, 32'hCAFEF00D);
        applyStimulus(32'h0, 1'b0, 4'b1111, 32'h0);

        for (int i = 0; i < 6; i++) begin
            ra = {20'd0, 2'b01, 8'($urandom_range(0, 255)), 2'b00};
            rd = $urandom;
            applyStimulus(ra, 1'b1, 4'($urandom_range(1, 15)), rd);
            applyStimulus(ra, 1'b0, 4'b0000, 32'h0);
        end

        // Zero wait states with strobe held high: exactly one ack per transaction.
        addr0 = 32'h40; we0 = 1'b1; sel0 = 4'hF; wdata0 = 32'h0BADF00D; cyc0 = 1'b1; stb0 = 1'b1;
        acks = 0; first = -1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack0) begin
                acks++;
                if (first < 0) first = i + 1;
            end
        end
        checkOutput("ws0_wr_acks", 32'(acks), 32'd1);
        checkOutput("ws0_wr_latency", 32'(first), 32'd1);
        cyc0 = 1'b0; stb0 = 1'b0;
        @(posedge clk); #1;

        we0 = 1'b0; cyc0 = 1'b1; stb0 = 1'b1;
        acks = 0; first = -1; got = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (err0) acks += 10;
            if (ack0) begin
                acks++;
                got = rdata0;
                if (first < 0) first = i + 1;
            end
        end
        checkOutput("ws0_rd_acks", 32'(acks), 32'd1);
        checkOutput("ws0_rd_latency", 32'(first), 32'd1);
        checkOutput("ws0_rd_data", got, 32'h0BADF00D);
        cyc0 = 1'b0; stb0 = 1'b0;
        @(posedge clk); #1;
        cyc0 = 1'b1; stb0 = 1'b1;
        @(posedge clk); #1;
        checkOutput("ws0_second_ack", {31'd0, ack0}, 32'd1);
        checkOutput("ws0_second_data", rdata0, 32'h0BADF00D);
        cyc0 = 1'b0; stb0 = 1'b0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
